screen_mux: RTL
===============

// Module: screen_mux
// PURPOSE
//  Final pixel stage of the Flappy Bird video path; consumes the rgb_if.in bundle
//  (start / game / gameover colours plus their valid flags) and drives the VGA output.
//  Owns the top-level screen FSM (START -> GAME -> GAMEOVER -> START).
//  Changes the displayed screen only on frame boundaries and aligns sync/blank to the pixel.
// PARAMETERS
//  HOLDOFF_FRAMES  60      frames in GAMEOVER during which flap is ignored (1..255)
//  BG_COLOR        12'h000 colour emitted when the selected source's valid is low
// PORTS
//  clk            input   1   pixel clock, all logic rising-edge
//  rst            input   1   asynchronous, active-high reset
//  rgb_in         rgb_if.in -  rgb_start/rgb_game/rgb_gameover[11:0], valid_start/valid_game/valid_gameover
//  hsync_in       input   1   horizontal sync aligned to rgb_in
//  vsync_in       input   1   vertical sync aligned to rgb_in (active-high pulse)
//  blank_in       input   1   blanking (hblnk | vblnk) aligned to rgb_in
//  flap           input   1   one-cycle pulse, debounced button press
//  collision      input   1   one-cycle pulse, bird hit pipe/ground
//  rgb_out        output  12  pixel to DAC
//  hsync_out      output  1   hsync_in delayed 1 cycle
//  vsync_out      output  1   vsync_in delayed 1 cycle
//  game_state     output  2   current FSM state (screen_t encoding)
//  game_active    output  1   1 while FSM state == S_GAME (enables bird/pipe physics)
// BEHAVIOUR
//  - Reset (async, rst=1): state=S_START, disp=S_START, holdoff cnt=0, vsync_d=0,
//    rgb_out=0, hsync_out=0, vsync_out=0, game_state=S_START, game_active=0.
//  - frame_tick = vsync_in & ~vsync_d (rising edge, one cycle per frame).
//  - FSM (registered, next-state comb):
//    S_START: flap -> S_GAME; collision ignored.
//    S_GAME : collision -> S_OVER (collision wins over simultaneous flap); flap ignored.
//    S_OVER : cnt clears to 0 on entry; cnt increments on frame_tick, saturates at HOLDOFF_FRAMES;
//             flap with cnt==HOLDOFF_FRAMES -> S_START; flap while cnt<HOLDOFF_FRAMES ignored.
//  - game_state/game_active reflect the state register (no extra delay).
//  - Displayed screen disp: loads the state register value present on the frame_tick cycle
//    (pre-update value if state changes that same cycle); held otherwise. Never changes mid-frame.
//  - Pixel select: src = disp==S_START ? start : disp==S_GAME ? game : gameover (rgb + valid).
//  - Pixel path, latency exactly 1 cycle:
//    rgb_out <= blank_in ? 12'h000 : (src_valid ? src_rgb : BG_COLOR);
//    hsync_out <= hsync_in; vsync_out <= vsync_in. Blanking always forces black, even if valid=1.
//  - Illegal state encoding (2'b11) -> S_START next cycle; disp 2'b11 selects BG_COLOR.
//  - Reset mid-frame: outputs drop to 0 immediately; screen restarts at START on first frame.
// STRUCTURE
//  - game_pkg: typedef enum logic [1:0] {S_START=2'd0, S_GAME=2'd1, S_OVER=2'd2} screen_t;
//    localparam BLACK = 12'h000. Shared with draw_* modules that read game_state.
//  - Sub-module frame_tick_gen (vsync edge detector: vsync_d reg + pulse), reused by physics.
//  - Rest: one FSM always_ff/always_comb pair, holdoff counter, disp reg, output pipeline reg.
// TESTING
//  1 rst pulse mid-line with rgb_game=12'hF00 valid -> all outputs 0 same cycle; game_state=0.
//  2 S_START, flap at line 100 -> game_state=1 next cycle; rgb_out stays rgb_start until next
//    vsync rising edge, then rgb_game (12'h0F0) from the following pixel, 1-cycle latency.
//  3 S_GAME, flap+collision same cycle -> game_state=2; cnt=0; game_active=0.
//  4 S_OVER, HOLDOFF_FRAMES=3: flap after 2 frame_ticks -> stays 2; flap after 3rd tick -> 0.
//  5 valid_gameover=0, disp=S_OVER, BG_COLOR=12'h00F -> rgb_out=12'h00F; blank_in=1 -> 12'h000.
//  6 collision on the frame_tick cycle -> disp latches S_GAME; gameover shown one frame later.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen encoding and colour constants for the Flappy Bird video path.
package game_pkg;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_GAME  = 2'd1,
    S_OVER  = 2'd2
  } screen_t;

  localparam int unsigned RGB_W = 12;
  localparam int unsigned CNT_W = 8;
  localparam logic [RGB_W-1:0] BLACK = 12'h000;

endpackage

// File: rtl/rgb_if.sv
// Colour bundle from the three screen renderers into the final pixel mux.
interface rgb_if;
  import game_pkg::*;

  logic [RGB_W-1:0] rgb_start;
  logic [RGB_W-1:0] rgb_game;
  logic [RGB_W-1:0] rgb_gameover;
  logic             valid_start;
  logic             valid_game;
  logic             valid_gameover;

  modport in (
    input rgb_start, rgb_game, rgb_gameover,
    input valid_start, valid_game, valid_gameover
  );

  modport out (
    output rgb_start, rgb_game, rgb_gameover,
    output valid_start, valid_game, valid_gameover
  );
endinterface

// File: rtl/frame_tick_gen.sv
// Vertical sync rising-edge detector: one-cycle pulse at the start of each frame.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick_c
);

  logic vsync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vsync_d <= 1'b0;
    else     vsync_d <= vsync;
  end

  assign tick_c = vsync & ~vsync_d;

endmodule

// File: rtl/screen_mux.sv
// Screen FSM and final pixel mux; the displayed screen only switches on frame ticks.
module screen_mux
  import game_pkg::*;
#(
  parameter int unsigned      HOLDOFF_FRAMES = 60,
  parameter logic [RGB_W-1:0] BG_COLOR       = 12'h000
) (
  input  logic             clk,
  input  logic             rst,
  rgb_if.in                rgb_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             blank_in,
  input  logic             flap,
  input  logic             collision,
  output logic [RGB_W-1:0] rgb_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [1:0]       game_state,
  output logic             game_active
);

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLDOFF_FRAMES);

  screen_t          state, state_next;
  screen_t          disp;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             frame_tick;
  logic [RGB_W-1:0] src_rgb;
  logic             src_valid;
  logic [RGB_W-1:0] pix_c;

  frame_tick_gen u_tick (
    .clk    (clk),
    .rst    (rst),
    .vsync  (vsync_in),
    .tick_c (frame_tick)
  );

  // State register, holdoff counter and the frame-aligned displayed screen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_START;
      cnt         <= '0;
      disp        <= S_START;
      game_active <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      game_active <= (state_next == S_GAME);
      if (frame_tick) disp <= state;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_START: if (flap) state_next = S_GAME;
      S_GAME: begin
        if (collision) begin
          state_next = S_OVER;
          cnt_next   = '0;
        end
      end
      S_OVER: begin
        if (frame_tick && (cnt < HOLD)) cnt_next = cnt + CNT_W'(1);
        if (flap && (cnt == HOLD)) state_next = S_START;
      end
      default: state_next = S_START;
    endcase
  end

  assign game_state = state;

  // Source select; an unknown screen code falls through to the background colour
  always_comb begin
    src_rgb   = BLACK;
    src_valid = 1'b0;
    case (disp)
      S_START: begin
        src_rgb   = rgb_in.rgb_start;
        src_valid = rgb_in.valid_start;
      end
      S_GAME: begin
        src_rgb   = rgb_in.rgb_game;
        src_valid = rgb_in.valid_game;
      end
      S_OVER: begin
        src_rgb   = rgb_in.rgb_gameover;
        src_valid = rgb_in.valid_gameover;
      end
      default: begin
        src_rgb   = BLACK;
        src_valid = 1'b0;
      end
    endcase
  end

  assign pix_c = blank_in ? BLACK : (src_valid ? src_rgb : BG_COLOR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out   <= BLACK;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb_out   <= pix_c;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule
